// File: rtl/exp_arbiter.sv
// Two-client arbiter in front of a single modular-exponentiation core.
// Grants alternate on ties, guard each job with a cycle timeout, and hold the last result.
module exp_arbiter #(
  parameter int TIMEOUT = 1048576
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req0,
  input  logic         req1,
  input  logic [511:0] x0,
  input  logic [511:0] e0,
  input  logic [511:0] x1,
  input  logic [511:0] e1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         err,
  output logic [511:0] result,
  output logic         busy,
  output logic         core_start,
  output logic [511:0] core_x,
  output logic [511:0] core_e,
  input  logic         core_done,
  input  logic [511:0] core_result
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           owner_q, owner_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           err_q, err_d;
  logic [511:0]   result_q, result_d;
  logic [511:0]   x_q, x_d;
  logic [511:0]   e_q, e_d;
  logic           pick;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      last_q   <= 1'b0;
      owner_q  <= 1'b0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      x_q      <= '0;
      e_q      <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      result_q <= result_d;
      x_q      <= x_d;
      e_q      <= e_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    timer_d    = timer_q;
    err_d      = err_q;
    result_d   = result_q;
    x_d        = x_q;
    e_d        = e_q;
    pick       = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    core_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the client that was not served last wins.
          pick    = (req0 && req1) ? ~last_q : req1;
          gnt0    = ~pick;
          gnt1    = pick;
          owner_d = pick;
          x_d     = pick ? x1 : x0;
          e_d     = pick ? e1 : e0;
          timer_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        core_start = 1'b1;
        timer_d    = timer_q + TW'(1);
        if (core_done) begin
          result_d = core_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        done0   = ~owner_q;
        done1   = owner_q;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign err    = err_q;
  assign result = result_q;
  assign core_x = x_q;
  assign core_e = e_q;

endmodule

// File: tb/tb_exp_arbiter.sv
// Bench for exp_arbiter: table of single jobs, randomized jobs against a job-level
// model, and hand sequences for ties, timeout, mid-job reset and dropped requests.
module tb_exp_arbiter;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [511:0] x0 = '0, e0 = '0, x1 = '0, e1 = '0;
  logic         gnt0, gnt1, done0, done1, err, busy, core_start, core_done;
  logic [511:0] result, core_x, core_e, core_result;

  int checks = 0;
  int errors = 0;

  // Core stub: done rises after stub_delay cycles of start; result is x + e.
  int stub_cnt;
  int stub_delay = 0;
  bit stub_never = 1'b0;
  bit stub_force = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) stub_cnt <= 0;
    else if (core_start) stub_cnt <= stub_cnt + 1;
    else stub_cnt <= 0;
  end

  assign core_done   = stub_force || (core_start && !stub_never && stub_cnt >= stub_delay);
  assign core_result = stub_force ? {512{1'b1}} : core_x + core_e;

  exp_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .req1(req1),
    .x0(x0), .e0(e0), .x1(x1), .e1(e1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err(err), .result(result), .busy(busy),
    .core_start(core_start), .core_x(core_x), .core_e(core_e),
    .core_done(core_done), .core_result(core_result)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    stub_never = 1'b0; stub_force = 1'b0;
    #1;
    chk("rst_async_start", core_start, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt0 | gnt1, 0);
    chk("rst_done", done0 | done1, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_core_e", core_e, 0);
    resetn = 1'b1;
  endtask

  // One complete job: request, grant, run, done pulse, then one idle cycle.
  task automatic run_job(input bit r0, input bit r1,
                         input logic [511:0] a0, input logic [511:0] b0,
                         input logic [511:0] a1, input logic [511:0] b1,
                         input int dly, input bit nev, input bit exp_own,
                         input int exp_lat, input bit exp_err, input logic [511:0] exp_res);
    int n, starts;
    bit got, own, unstable;
    logic [511:0] ex, ee;
    @(posedge clk); #1;
    req0 = r0; req1 = r1; x0 = a0; e0 = b0; x1 = a1; e1 = b1;
    stub_delay = dly; stub_never = nev;
    got = 1'b0; own = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        got = 1'b1;
        own = gnt1;
        chk("gnt_onehot", gnt0 & gnt1, 0);
        chk("gnt_busy_low", busy, 0);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("gnt_seen", got, 1);
    if (!got) return;
    chk("gnt_owner", own, exp_own);
    ex = exp_own ? a1 : a0;
    ee = exp_own ? b1 : b0;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; x0 = ~a0; e0 = ~b0; x1 = ~a1; e1 = ~b1;
    n = 0; starts = 0; got = 1'b0; unstable = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      n++;
      if (core_start) starts++;
      if (core_x !== ex || core_e !== ee) unstable = 1'b1;
      if (done0 || done1) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("done_seen", got, 1);
    chk("latency", n, exp_lat);
    chk("done0", done0, !exp_own);
    chk("done1", done1, exp_own);
    chk("err", err, exp_err);
    chk("result", result, exp_res);
    chk("start_cycles", starts, exp_lat - 1);
    chk("operands_stable", unstable, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_start", core_start, 0);
    chk("idle_done", done0 | done1, 0);
    chk("result_held", result, exp_res);
  endtask

  typedef struct {
    bit           r0, r1;
    logic [511:0] a0, b0, a1, b1;
    int           dly;
    bit           nev;
    bit           own;
    int           lat;
    bit           err;
    logic [511:0] res;
  } vec_t;

  vec_t vt[6];
  bit           m_last;
  logic [511:0] m_res;

  initial begin
    // Rows run back-to-back after reset; arbitration history carries between rows.
    vt[0] = '{1, 0,   5,  3,   0,  0, 10, 0, 0, 12, 0,   8};
    vt[1] = '{0, 1,   0,  0, 100, 23,  0, 0, 1,  2, 0, 123};
    vt[2] = '{1, 1,   7,  1,   9,  9,  3, 0, 0,  5, 0,   8};
    vt[3] = '{1, 1,   1,  1,  40,  2, 15, 0, 1, 17, 0,  42};
    vt[4] = '{1, 0,   3,  4,   0,  0,  0, 1, 0, 17, 1,  42};
    vt[5] = '{0, 1,   0,  0,   2,  2, 14, 0, 1, 16, 0,   4};

    do_reset();
    foreach (vt[i])
      run_job(vt[i].r0, vt[i].r1, vt[i].a0, vt[i].b0, vt[i].a1, vt[i].b1,
              vt[i].dly, vt[i].nev, vt[i].own, vt[i].lat, vt[i].err, vt[i].res);

    // Randomized jobs against a job-level model.
    m_last = 1'b1;
    m_res  = 512'd4;
    for (int k = 0; k < 40; k++) begin
      int pat, d, lat;
      bit nev, own, timed, r0, r1;
      logic [511:0] a0, b0, a1, b1, res;
      pat = $urandom_range(1, 3);
      r0 = pat[0]; r1 = pat[1];
      d = $urandom_range(0, 20);
      nev = ($urandom_range(0, 7) == 0);
      a0 = rnd512(); b0 = rnd512(); a1 = rnd512(); b1 = rnd512();
      own = (r0 && r1) ? !m_last : r1;
      timed = nev || (d > TO - 1);
      lat = timed ? TO + 1 : d + 2;
      res = timed ? m_res : (own ? a1 + b1 : a0 + b0);
      run_job(r0, r1, a0, b0, a1, b1, d, nev, own, lat, timed, res);
      m_last = own;
      m_res = res;
    end

    // Both clients requesting continuously from reset: 1,0,1,0 with 2-cycle start gaps.
    begin
      bit q_g[$], q_d[$];
      int ndone, lowrun, gaps, badgap;
      bit prev_start, busy1;
      logic [3:0] gbits, dbits;
      do_reset();
      req0 = 1'b1; req1 = 1'b1; stub_delay = 2;
      x0 = 100; e0 = 1; x1 = 200; e1 = 2;
      #1;
      chk("tie_first_gnt1", gnt1, 1);
      chk("tie_first_gnt0", gnt0, 0);
      ndone = 0; lowrun = 0; gaps = 0; badgap = 0; prev_start = 1'b0; busy1 = 1'b0;
      for (int i = 0; i < 120 && ndone < 4; i++) begin
        if (i > 0) begin
          @(posedge clk);
          @(negedge clk);
        end
        if (i == 1) busy1 = busy;
        if (gnt0 || gnt1) q_g.push_back(gnt1);
        if (done0 || done1) begin
          q_d.push_back(done1);
          ndone++;
        end
        if (core_start) begin
          if (!prev_start && q_g.size() > 1) begin
            gaps++;
            if (lowrun != 2) badgap++;
          end
          lowrun = 0;
        end else begin
          lowrun++;
        end
        prev_start = core_start;
      end
      req0 = 1'b0; req1 = 1'b0;
      gbits = '0; dbits = '0;
      for (int i = 0; i < 4; i++) begin
        if (i < q_g.size()) gbits[3-i] = q_g[i];
        if (i < q_d.size()) dbits[3-i] = q_d[i];
      end
      chk("alt_busy_after_first_edge", busy1, 1);
      chk("alt_ndone", ndone, 4);
      chk("alt_ngrants", q_g.size(), 4);
      chk("alt_grant_order", gbits, 4'b1010);
      chk("alt_done_order", dbits, 4'b1010);
      chk("alt_gaps", gaps, 3);
      chk("alt_bad_gaps", badgap, 0);
      chk("alt_last_result", result, 101);
    end

    // Reset five cycles into a job: silent abort, then a normal job.
    begin
      int dn;
      do_reset();
      @(posedge clk); #1;
      req0 = 1'b1; x0 = 11; e0 = 22; stub_never = 1'b1;
      @(negedge clk);
      chk("mid_gnt0", gnt0, 1);
      @(posedge clk); #1;
      req0 = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("mid_running", core_start, 1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_start", core_start, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_core_x", core_x, 0);
      chk("mid_rst_core_e", core_e, 0);
      dn = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done0 || done1) dn++;
      end
      chk("mid_rst_no_done", dn, 0);
      stub_never = 1'b0;
      resetn = 1'b1;
      run_job(1, 0, 11, 22, 0, 0, 4, 0, 0, 6, 0, 33);
    end

    // One-cycle req1 pulse during a client 0 job is never granted.
    begin
      bit g1, d0, quiet;
      @(posedge clk); #1;
      req0 = 1'b1; x0 = 20; e0 = 30; stub_delay = 8; stub_never = 1'b0;
      @(negedge clk);
      chk("pulse_gnt0", gnt0, 1);
      g1 = 1'b0; d0 = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = (i == 3);
        @(negedge clk);
        if (gnt1) g1 = 1'b1;
        if (done0) d0 = 1'b1;
      end
      chk("pulse_no_gnt1", g1, 0);
      chk("pulse_done0", d0, 1);
      chk("pulse_result", result, 50);

      // core_done while idle must not produce a response.
      stub_force = 1'b1;
      quiet = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (done0 || done1 || busy) quiet = 1'b1;
      end
      stub_force = 1'b0;
      chk("idle_core_done_ignored", quiet, 0);
      chk("idle_result_kept", result, 50);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
